// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture family: default widths,
// timeout and the capture FSM state encoding.
package pwm_pkg;

    localparam int unsigned W_DEFAULT       = 32;
    localparam int unsigned NCH_DEFAULT     = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } capState_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Pin-side inputs and per-channel measurement results of the PWM capture block.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned W   = W_DEFAULT
);
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   pwm_in;
    logic [NCH*W-1:0] period_o;
    logic [NCH*W-1:0] duty_o;
    logic [NCH-1:0]   valid_o;
    logic [NCH-1:0]   timeout_o;

    modport master (
        output en, pwm_in,
        input  period_o, duty_o, valid_o, timeout_o
    );

    modport slave (
        input  en, pwm_in,
        output period_o, duty_o, valid_o, timeout_o
    );
endinterface

// File: rtl/pwm_capture_ch.sv
// One capture channel: pin synchronizer, rising-edge detect, capture FSM,
// period/high-time counters and registered results.
module pwm_capture_ch
    import pwm_pkg::*;
#(
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         pinIn,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic         valid,
    output logic         timeout
);

    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

    logic sync1;
    logic syncS;
    logic syncD;
    logic rise;

    capState_e    state;
    capState_e    stateNxt;
    logic [W-1:0] cntP;
    logic [W-1:0] cntPNxt;
    logic [W-1:0] cntH;
    logic [W-1:0] cntHNxt;
    logic [W-1:0] periodNxt;
    logic [W-1:0] dutyNxt;
    logic         validNxt;
    logic         timeoutNxt;

    // Synchronizer keeps running while disabled so the line level is known at re-enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            syncS <= 1'b0;
            syncD <= 1'b0;
        end else begin
            sync1 <= pinIn;
            syncS <= sync1;
            syncD <= syncS;
        end
    end

    assign rise = syncS & ~syncD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cntP    <= '0;
            cntH    <= '0;
            period  <= '0;
            duty    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= stateNxt;
            cntP    <= cntPNxt;
            cntH    <= cntHNxt;
            period  <= periodNxt;
            duty    <= dutyNxt;
            valid   <= validNxt;
            timeout <= timeoutNxt;
        end
    end

    // A rise in MEASURE takes priority over the timeout check
    always_comb begin
        stateNxt   = state;
        cntPNxt    = cntP;
        cntHNxt    = cntH;
        periodNxt  = period;
        dutyNxt    = duty;
        validNxt   = 1'b0;
        timeoutNxt = timeout;

        if (!en) begin
            stateNxt   = IDLE;
            cntPNxt    = '0;
            cntHNxt    = '0;
            periodNxt  = '0;
            dutyNxt    = '0;
            timeoutNxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!syncS) stateNxt = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        stateNxt = MEASURE;
                        cntPNxt  = W'(1);
                        cntHNxt  = W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        periodNxt  = cntP;
                        dutyNxt    = cntH;
                        validNxt   = 1'b1;
                        timeoutNxt = 1'b0;
                        cntPNxt    = W'(1);
                        cntHNxt    = W'(1);
                    end else if (cntP == TIMEOUT_W) begin
                        timeoutNxt = 1'b1;
                        periodNxt  = '0;
                        dutyNxt    = '0;
                        cntPNxt    = '0;
                        cntHNxt    = '0;
                        stateNxt   = IDLE;
                    end else begin
                        cntPNxt = cntP + W'(1);
                        if (syncS) cntHNxt = cntH + W'(1);
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM capture: NCH independent channels reporting period and
// high time in clk cycles, with a valid strobe and sticky timeout per channel.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned NCH     = NCH_DEFAULT,
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);

    logic [W-1:0] periodArr  [NCH];
    logic [W-1:0] dutyArr    [NCH];
    logic         validArr   [NCH];
    logic         timeoutArr [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_capture_ch #(
            .W       (W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en[k]),
            .pinIn   (bus.pwm_in[k]),
            .period  (periodArr[k]),
            .duty    (dutyArr[k]),
            .valid   (validArr[k]),
            .timeout (timeoutArr[k])
        );
    end

    // Pack per-channel results; channel k occupies bits [k*W +: W]
    always_comb begin
        bus.period_o  = '0;
        bus.duty_o    = '0;
        bus.valid_o   = '0;
        bus.timeout_o = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.period_o[k*W +: W] = periodArr[k];
            bus.duty_o[k*W +: W]   = dutyArr[k];
            bus.valid_o[k]         = validArr[k];
            bus.timeout_o[k]       = timeoutArr[k];
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform generators per channel, expectations from the
// generated period/high time and edge timing.
module tb_pwm_capture;

    localparam int unsigned NCH = 8;
    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 1000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pwm_capture_if #(.NCH(NCH), .W(W)) bus ();

    pwm_capture #(.NCH(NCH), .W(W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit             genOn [NCH];
    int             genP  [NCH];
    int             genH  [NCH];
    int             ph    [NCH];
    logic [NCH-1:0] pins;

    bit chk           [NCH];
    int expP          [NCH];
    int expD          [NCH];
    int vCnt          [NCH];
    int firstValidCyc [NCH];
    int lastValidCyc  [NCH];

    typedef struct {
        int ch;
        int p;
        int h;
        int cycles;
        int expValids;
        int expPeriod;
        int expDuty;
        bit expTmo;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [63:0] perOf(int k);
        return 64'(bus.period_o[k*W +: W]);
    endfunction

    function automatic logic [63:0] dutOf(int k);
        return 64'(bus.duty_o[k*W +: W]);
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance generators, drive pins, sample after the edge, score valids
    task automatic tick();
        for (int k = 0; k < NCH; k++) begin
            if (genOn[k]) begin
                pins[k] = (ph[k] < genH[k]);
                ph[k]   = (ph[k] + 1) % genP[k];
            end
        end
        bus.pwm_in = pins;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NCH; k++) begin
            if (bus.valid_o[k] === 1'b1) begin
                vCnt[k]++;
                if (firstValidCyc[k] < 0) firstValidCyc[k] = cyc;
                lastValidCyc[k] = cyc;
                if (chk[k]) begin
                    check($sformatf("ch%0d period", k), perOf(k), 64'(expP[k]));
                    check($sformatf("ch%0d duty", k), dutOf(k), 64'(expD[k]));
                end
            end
        end
    endtask

    task automatic startGen(int k, int p, int h);
        genOn[k] = 1'b1;
        genP[k]  = p;
        genH[k]  = h;
        ph[k]    = 0;
        chk[k]   = 1'b1;
        expP[k]  = p;
        expD[k]  = h;
    endtask

    task automatic stopGen(int k, logic lvl);
        genOn[k] = 1'b0;
        pins[k]  = lvl;
    endtask

    task automatic clearStats();
        for (int k = 0; k < NCH; k++) begin
            vCnt[k]          = 0;
            firstValidCyc[k] = -1;
            lastValidCyc[k]  = -1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            genOn[k] = 1'b0;
            chk[k]   = 1'b0;
        end
        pins       = '0;
        bus.pwm_in = '0;
        bus.en     = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        clearStats();
    endtask

    task automatic checkAllZero(string nm);
        check({nm, " period_o"}, 64'(bus.period_o != '0), 64'd0);
        check({nm, " duty_o"}, 64'(bus.duty_o != '0), 64'd0);
        check({nm, " valid_o"}, 64'(bus.valid_o), 64'd0);
        check({nm, " timeout_o"}, 64'(bus.timeout_o), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int target;
        int others;

        rst_n      = 1'b0;
        bus.en     = '1;
        bus.pwm_in = '0;
        pins       = '0;
        clearStats();

        // Reset and steady state with idle lines
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("in reset");
        doReset();
        repeat (20) tick();
        checkAllZero("idle after reset");
        others = 0;
        for (int k = 0; k < NCH; k++) others += vCnt[k];
        check("idle valids", 64'(others), 64'd0);

        // Table-driven single-channel waveforms
        vecs[0] = '{0, 100, 30, 300, 2, 100, 30, 1'b0};
        vecs[1] = '{4, 10, 3, 55, 5, 10, 3, 1'b0};
        vecs[2] = '{5, 2, 1, 20, 8, 2, 1, 1'b0};
        vecs[3] = '{6, 37, 36, 120, 3, 37, 36, 1'b0};
        vecs[4] = '{7, 5, 5, 1010, 0, 0, 0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            doReset();
            c0 = cyc;
            startGen(vecs[i].ch, vecs[i].p, vecs[i].h);
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d valid count", i), 64'(vCnt[vecs[i].ch]), 64'(vecs[i].expValids));
            check($sformatf("vec%0d period", i), perOf(vecs[i].ch), 64'(vecs[i].expPeriod));
            check($sformatf("vec%0d duty", i), dutOf(vecs[i].ch), 64'(vecs[i].expDuty));
            check($sformatf("vec%0d timeout", i), 64'(bus.timeout_o[vecs[i].ch]), 64'(vecs[i].expTmo));
            if (vecs[i].expValids > 0)
                check($sformatf("vec%0d first valid latency", i),
                      64'(firstValidCyc[vecs[i].ch] - c0), 64'(vecs[i].p + 3));
            others = 0;
            for (int k = 0; k < NCH; k++) if (k != vecs[i].ch) others += vCnt[k] + int'(perOf(k) != 0);
            check($sformatf("vec%0d other channels quiet", i), 64'(others), 64'd0);
        end

        // Line already high when the channel is enabled
        doReset();
        bus.en[1] = 1'b0;
        pins[1]   = 1'b1;
        repeat (10) tick();
        bus.en[1] = 1'b1;
        repeat (10) tick();
        pins[1] = 1'b0;
        repeat (50) tick();
        check("ch1 no valid before first true rise", 64'(vCnt[1]), 64'd0);
        c0 = cyc;
        startGen(1, 100, 20);
        repeat (102) tick();
        check("ch1 no early valid", 64'(vCnt[1]), 64'd0);
        tick();
        check("ch1 valid after full period", 64'(vCnt[1]), 64'd1);
        check("ch1 valid latency", 64'(firstValidCyc[1] - c0), 64'd103);

        // Timeout on ch2 and recovery
        doReset();
        startGen(2, 200, 50);
        repeat (250) tick();
        stopGen(2, 1'b0);
        check("ch2 one valid before timeout", 64'(vCnt[2]), 64'd1);
        target = lastValidCyc[2] + int'(TMO) - 1;
        for (int n = 0; n < 3000 && cyc < target; n++) tick();
        check("ch2 wait reached", 64'(cyc), 64'(target));
        check("ch2 timeout not yet", 64'(bus.timeout_o[2]), 64'd0);
        check("ch2 period held", perOf(2), 64'd200);
        tick();
        check("ch2 timeout set", 64'(bus.timeout_o[2]), 64'd1);
        check("ch2 period cleared", perOf(2), 64'd0);
        check("ch2 duty cleared", dutOf(2), 64'd0);
        repeat (10) tick();
        check("ch2 timeout sticky", 64'(bus.timeout_o[2]), 64'd1);
        c0 = cyc;
        startGen(2, 200, 50);
        repeat (203) tick();
        check("ch2 fresh valid", 64'(vCnt[2]), 64'd2);
        check("ch2 fresh valid latency", 64'(lastValidCyc[2] - c0), 64'd203);
        check("ch2 timeout cleared", 64'(bus.timeout_o[2]), 64'd0);

        // Disable ch3 mid-period
        doReset();
        startGen(3, 60, 20);
        repeat (150) tick();
        check("ch3 valids before disable", 64'(vCnt[3]), 64'd2);
        bus.en[3] = 1'b0;
        tick();
        check("ch3 period after disable", perOf(3), 64'd0);
        check("ch3 duty after disable", dutOf(3), 64'd0);
        check("ch3 valid after disable", 64'(bus.valid_o[3]), 64'd0);
        repeat (130) tick();
        check("ch3 no valid while disabled", 64'(vCnt[3]), 64'd2);
        bus.en[3] = 1'b1;
        repeat (200) tick();
        check("ch3 resumes after enable", 64'(vCnt[3] > 2), 64'd1);

        // Reset pulse mid-period
        doReset();
        startGen(0, 100, 30);
        startGen(5, 50, 10);
        repeat (180) tick();
        check("ch5 valids before reset pulse", 64'(vCnt[5]), 64'd3);
        check("ch0 period before reset pulse", perOf(0), 64'd100);
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        clearStats();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("no valid after reset pulse", 64'(vCnt[0] + vCnt[5]), 64'd0);
        checkAllZero("after reset pulse");
        repeat (150) tick();
        check("ch5 measures after reset pulse", 64'(vCnt[5] > 0), 64'd1);

        // Two channels concurrently: fast PWM on ch0, constant high on ch7
        doReset();
        startGen(0, 10, 3);
        startGen(7, 7, 7);
        repeat (1020) tick();
        check("ch0 concurrent valid count", 64'(vCnt[0]), 64'd101);
        check("ch0 concurrent period", perOf(0), 64'd10);
        check("ch0 no timeout", 64'(bus.timeout_o[0]), 64'd0);
        check("ch7 no valid", 64'(vCnt[7]), 64'd0);
        check("ch7 timeout", 64'(bus.timeout_o[7]), 64'd1);
        check("ch7 period", perOf(7), 64'd0);
        check("ch7 duty", dutOf(7), 64'd0);

        // Random per-channel period/duty on all channels at once
        for (int r = 0; r < 3; r++) begin
            int rp [NCH];
            int runLen;
            doReset();
            for (int k = 0; k < NCH; k++) begin
                rp[k] = int'($urandom_range(60, 2));
                startGen(k, rp[k], int'($urandom_range(rp[k] - 1, 1)));
            end
            runLen = int'($urandom_range(900, 300));
            repeat (runLen) tick();
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("rnd%0d ch%0d valid count", r, k), 64'(vCnt[k]), 64'((runLen - 3) / rp[k]));
                check($sformatf("rnd%0d ch%0d timeout", r, k), 64'(bus.timeout_o[k]), 64'd0);
                check($sformatf("rnd%0d ch%0d duty<=period", r, k), 64'(dutOf(k) <= perOf(k)), 64'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Multi-channel PWM capture block: the receive-side counterpart of the team's pwm generator.
- Measures incoming PWM lines from servo/ESC feedback, RC receivers or loop-back of generator outputs.
- Per channel it reports period (T) and high time (D) in clk cycles, matching the generator's T/D register semantics, plus a valid strobe and a timeout flag.
- Sits between the I/O pins and the control/bus-register logic.

Parameters:
- NCH, 8, number of independent capture channels.
- W, 32, counter and result width in bits.
- TIMEOUT, 50_000_000, cycles without a rising edge before a channel declares timeout; legal range 2 to 2^W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  NCH  per-channel enable.
- pwm_in  input  NCH  asynchronous PWM inputs.
- period_o  output  NCH*W  channel k at bits [k*W +: W]; last measured period in cycles.
- duty_o  output  NCH*W  channel k at bits [k*W +: W]; last measured high time in cycles.
- valid_o  output  NCH  one-cycle strobe when channel k's period_o/duty_o update.
- timeout_o  output  NCH  sticky flag: no rising edge within TIMEOUT cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - Synchronizer flops, edge register and counters are 0.
  - All channels go to IDLE.
- Input conditioning, per channel:
  - 2-flop synchronizer gives s.
  - A registered copy s_d gives rise = s & ~s_d.
  - Pin-to-rise latency is 3 clk.
- Per-channel FSM:
  - IDLE: wait for s==0, then go to ARMED. This prevents a line that is already high at reset or enable from producing a false edge.
  - ARMED: on rise, go to MEASURE with cnt_p=1 and cnt_h=1. No valid strobe.
  - MEASURE, cycle with rise:
    - period_o <= cnt_p and duty_o <= cnt_h.
    - valid_o pulses for 1 cycle.
    - timeout_o <= 0.
    - cnt_p <= 1, cnt_h <= 1.
  - MEASURE, cycle without rise:
    - cnt_p <= cnt_p + 1.
    - cnt_h <= cnt_h + 1 when s==1.
  - MEASURE, cycle without rise and cnt_p == TIMEOUT:
    - timeout_o <= 1.
    - period_o <= 0 and duty_o <= 0.
    - No valid strobe; go to IDLE.
- Simultaneous rise and cnt_p==TIMEOUT: the rise wins and a normal measurement is taken.
- First valid_o comes after the second rising edge seen in ARMED/MEASURE.
- Width rules:
  - cnt_p never exceeds TIMEOUT, so there is no wrap.
  - duty_o <= period_o always.
  - A constant-high line times out, producing duty 0 and period 0, with timeout_o = 1.
- en[k] low:
  - The channel goes to IDLE synchronously.
  - Its counters, period_o, duty_o, valid_o and timeout_o clear to 0 on the next clk.
  - Re-enabling restarts from IDLE.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset asserted mid-measurement aborts immediately. No valid_o is produced for the partial period.

Decomposition:
- Shared package pwm_pkg holds:
  - Default W (32).
  - The capture FSM state encoding: IDLE=2'd0, ARMED=2'd1, MEASURE=2'd2.
  - A TIMEOUT_DEFAULT constant.
- One sub-module, pwm_capture_ch, contains a single channel: synchronizer, edge detect, FSM, counters and result registers.
- The top pwm_capture instantiates NCH copies in a generate loop and packs the buses.

Test Plan:
- Reset/steady state: hold rst_n=0, then release with en=all 1 and pwm_in=0 -> all outputs 0, no valid_o, timeout_o=0.
- Basic measure on ch0, 100-cycle period with 30 high, repeated 3 times -> valid_o[0] on the 2nd and 3rd edges (3 clk after each pin edge), period_o=100, duty_o=30; other channels stay 0.
- High at enable on ch1: pwm_in[1]=1, assert en[1], then low 50, high 20, low 80, high... -> no valid until a full period after the first true rise; then period 100, duty 20.
- Timeout on ch2 with TIMEOUT=1000 (bench override), one measured period of 200/50, then line held low -> at 1000 cycles after the last rise timeout_o[2]=1 and period_o=duty_o=0. The next two rises clear timeout_o with a fresh valid.
- Disable/reset mid-op: en[3] dropped mid-period -> ch3 outputs 0 next cycle. Separately, rst_n pulsed low for 1 cycle mid-period on all channels -> outputs 0 and no spurious valid_o.
- Concurrency: ch0 at 10/3 and ch7 at 7/7 (always high at period 7 times out), run together -> ch0 reports 10/3 every 10 cycles; ch7 times out with no cross-coupling.
